// File: rtl/dram_ctrl.sv
// Front-end for the single-port dram array: round-robin arbitration of two requesters
// plus periodic read/writeback refresh sweeps. Optional stats under DRAM_CTRL_STATS_EN.
module dram_ctrl #(
  parameter int ADDR_W           = 12,
  parameter int DATA_W           = 8,
  parameter int REFRESH_INTERVAL = 512,
  parameter int REFRESH_BURST    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy,
  output logic              ref_overrun,
  output logic [15:0]       ref_count
);

  localparam int TMR_W = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam int BST_W = $clog2(REFRESH_BURST + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(REFRESH_INTERVAL - 1);
  localparam logic [BST_W-1:0] BST_LOAD = BST_W'(REFRESH_BURST);

  typedef enum logic [2:0] {IDLE, WR, RD, RD_CAP, REF_RD, REF_CAP, REF_WB} state_t;

  state_t              state, state_nx;
  logic [TMR_W-1:0]    timer;
  logic                tick;
  logic                ref_pending;
  logic                ref_done;
  logic [ADDR_W-1:0]   ptr, ptr_nx;
  logic [BST_W-1:0]    burst_cnt;
  logic                rr_last;
  logic                cmd_id;
  logic                idle_free;
  logic                grant0, grant1;
  logic                accept;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  assign tick      = (timer == TMR_LAST);
  assign idle_free = (state == IDLE) && !ref_pending;
  // With both valid, the side that did not win last time is served.
  assign grant0    = req0_valid && (!req1_valid || rr_last);
  assign grant1    = req1_valid && (!req0_valid || !rr_last);
  assign req0_ready = idle_free && grant0;
  assign req1_ready = idle_free && grant1;
  assign accept    = req0_ready || req1_ready;
  assign sel_we    = grant1 ? req1_we    : req0_we;
  assign sel_addr  = grant1 ? req1_addr  : req0_addr;
  assign sel_wdata = grant1 ? req1_wdata : req0_wdata;
  assign ref_done  = (state == REF_WB) && (burst_cnt == BST_W'(1));
  assign ptr_nx    = (state == REF_WB) ? ptr + ADDR_W'(1) : ptr;
  assign busy      = (state != IDLE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (ref_pending)  state_nx = REF_RD;
        else if (accept)  state_nx = sel_we ? WR : RD;
      end
      WR:      state_nx = IDLE;
      RD:      state_nx = RD_CAP;
      RD_CAP:  state_nx = IDLE;
      REF_RD:  state_nx = REF_CAP;
      REF_CAP: state_nx = REF_WB;
      REF_WB:  state_nx = ref_done ? IDLE : REF_RD;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      timer       <= '0;
      ref_pending <= 1'b0;
      ptr         <= '0;
      burst_cnt   <= '0;
      rr_last     <= 1'b1;
      cmd_id      <= 1'b0;
    end else begin
      state <= state_nx;
      timer <= tick ? '0 : timer + TMR_W'(1);
      // A wrap re-arms the request even on the last writeback of a burst.
      if (tick)          ref_pending <= 1'b1;
      else if (ref_done) ref_pending <= 1'b0;
      if (state == IDLE && ref_pending) burst_cnt <= BST_LOAD;
      else if (state == REF_WB)         burst_cnt <= burst_cnt - BST_W'(1);
      ptr <= ptr_nx;
      if (accept) begin
        rr_last <= req1_ready;
        cmd_id  <= req1_ready;
      end
    end
  end

  // Memory-side registers are loaded on entry to the state that uses them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_address <= '0;
      mem_data_in <= '0;
      mem_we      <= 1'b0;
    end else begin
      mem_we <= (state_nx == WR) || (state_nx == REF_WB);
      case (state_nx)
        WR: begin
          mem_address <= sel_addr;
          mem_data_in <= sel_wdata;
        end
        RD:      mem_address <= sel_addr;
        REF_RD:  mem_address <= ptr_nx;
        REF_WB:  mem_data_in <= mem_data_out;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp1_rdata <= '0;
    end else begin
      rsp0_valid <= (state == RD_CAP) && !cmd_id;
      rsp1_valid <= (state == RD_CAP) && cmd_id;
      if (state == RD_CAP && !cmd_id) rsp0_rdata <= mem_data_out;
      if (state == RD_CAP && cmd_id)  rsp1_rdata <= mem_data_out;
    end
  end

`ifdef DRAM_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ref_overrun <= 1'b0;
      ref_count   <= '0;
    end else begin
      if (tick && ref_pending) ref_overrun <= 1'b1;
      if (ref_done && ref_count != 16'hFFFF) ref_count <= ref_count + 16'd1;
    end
  end
`else
  assign ref_overrun = 1'b0;
  assign ref_count   = '0;
`endif

endmodule

// File: tb/tb_dram_ctrl.sv
// Bench for dram_ctrl: cycle-level reference model with randomized requester traffic,
// plus a second instance with a short refresh interval for overrun behaviour.
module tb_dram_ctrl;
  localparam int AW = 12, DW = 8, RI = 16, RB = 2, OI = 4, OB = 4;
  localparam int M_IDLE = 0, M_DIR = 1, M_RND = 2;
`ifdef DRAM_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct { int cyc; logic [AW-1:0] a; logic [DW-1:0] d; bit r; } ev_t;
  typedef struct { bit we; logic [AW-1:0] a; logic [DW-1:0] d; } cmd_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic req0_valid, req0_ready, req0_we, rsp0_valid;
  logic req1_valid, req1_ready, req1_we, rsp1_valid;
  logic [AW-1:0] req0_addr, req1_addr, mem_address;
  logic [DW-1:0] req0_wdata, req1_wdata, rsp0_rdata, rsp1_rdata;
  logic [DW-1:0] mem_data_in, mem_data_out;
  logic mem_we, busy, ref_overrun;
  logic [15:0] ref_count;

  logic o_req0_ready, o_req1_ready, o_rsp0_valid, o_rsp1_valid, o_we, o_busy, o_ovr;
  logic [DW-1:0] o_rsp0_rdata, o_rsp1_rdata, o_din, o_dout;
  logic [AW-1:0] o_addr;
  logic [15:0] o_cnt;

  dram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .REFRESH_INTERVAL(RI), .REFRESH_BURST(RB)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_we(mem_we),
    .mem_data_out(mem_data_out), .busy(busy), .ref_overrun(ref_overrun), .ref_count(ref_count));

  dram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .REFRESH_INTERVAL(OI), .REFRESH_BURST(OB)) u_ovr (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(1'b0), .req0_ready(o_req0_ready), .req0_we(1'b0),
    .req0_addr('0), .req0_wdata('0), .rsp0_valid(o_rsp0_valid), .rsp0_rdata(o_rsp0_rdata),
    .req1_valid(1'b0), .req1_ready(o_req1_ready), .req1_we(1'b0),
    .req1_addr('0), .req1_wdata('0), .rsp1_valid(o_rsp1_valid), .rsp1_rdata(o_rsp1_rdata),
    .mem_address(o_addr), .mem_data_in(o_din), .mem_we(o_we),
    .mem_data_out(o_dout), .busy(o_busy), .ref_overrun(o_ovr), .ref_count(o_cnt));

  function automatic logic [DW-1:0] pat(input int a);
    return DW'(a) ^ DW'(a >> 4) ^ 8'h5A;
  endfunction

  // dram arrays: 1-cycle registered read; main array preloaded with pat() while in reset
  logic [DW-1:0] dmem [1<<AW];
  logic [DW-1:0] omem [1<<AW];
  logic [AW:0]   init_ptr = '0;
  always @(posedge clk) begin
    if (!init_ptr[AW]) begin
      dmem[init_ptr[AW-1:0]] <= pat(int'(init_ptr));
      init_ptr <= init_ptr + 1'b1;
    end else if (mem_we) begin
      dmem[mem_address] <= mem_data_in;
    end
    mem_data_out <= dmem[mem_address];
  end
  always @(posedge clk) begin
    if (o_we) omem[o_addr] <= o_din;
    o_dout <= omem[o_addr];
  end

  int checks = 0, failures = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model state
  int c, free_at, clr_at, m_cnt, ref_last_start;
  bit pend, m_ovr, rr;
  logic [AW-1:0] ptr_m;
  logic [DW-1:0] mmem [1<<AW];
  ev_t wq[$], rq0[$], rq1[$];
  // stimulus state
  bit v[2], cwe[2], acc[2];
  logic [AW-1:0] ca[2];
  logic [DW-1:0] cd[2];
  cmd_t scr0[$], scr1[$];
  int mode, wrap_seen;
  int grants[$];
  bit after_fff;
  logic [DW-1:0] last_rd0, last_rd1;

  task automatic model_reset();
    c = 0; free_at = 0; clr_at = -1; m_cnt = 0; pend = 0; m_ovr = 0; rr = 1; ptr_m = '0;
    wq.delete(); rq0.delete(); rq1.delete();
    acc[0] = 0; acc[1] = 0; after_fff = 0;
  endtask

  task automatic step_model();
    bit tick, clr, e0, e1, id, ew;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    ev_t e;
    tick = (c > 0) && (c % RI == 0);
    clr  = (c == clr_at);
    if (clr) m_cnt++;
    if (tick) begin
      if (pend) m_ovr = 1;
      pend = 1;
    end else if (clr) pend = 0;
    e0 = 0; e1 = 0;
    chk("busy", busy, c < free_at);
    if (c >= free_at) begin
      if (pend) begin
        for (int k = 0; k < RB; k++) begin
          a = ptr_m + AW'(k);
          wq.push_back('{c + 3 + 3*k, a, mmem[a], 1'b1});
        end
        ptr_m = ptr_m + AW'(RB);
        free_at = c + 3*RB + 1;
        clr_at = free_at;
        ref_last_start = c;
      end else begin
        if (req0_valid && req1_valid) begin
          e0 = rr; e1 = !rr;
        end else begin
          e0 = req0_valid; e1 = req1_valid;
        end
        if (e0 || e1) begin
          id = e1;
          a = id ? req1_addr : req0_addr;
          d = id ? req1_wdata : req0_wdata;
          rr = id;
          if (id ? req1_we : req0_we) begin
            mmem[a] = d;
            wq.push_back('{c + 1, a, d, 1'b0});
            free_at = c + 2;
          end else begin
            if (id) rq1.push_back('{c + 3, a, mmem[a], 1'b0});
            else    rq0.push_back('{c + 3, a, mmem[a], 1'b0});
            free_at = c + 3;
          end
        end
      end
    end
    chk("req0_ready", req0_ready, e0);
    chk("req1_ready", req1_ready, e1);
    acc[0] = req0_valid && req0_ready;
    acc[1] = req1_valid && req1_ready;
    if (acc[0]) grants.push_back(0);
    if (acc[1]) grants.push_back(1);
    ew = (wq.size() > 0) && (wq[0].cyc == c);
    chk("mem_we", mem_we, ew);
    if (ew) begin
      e = wq.pop_front();
      chk("mem_addr", mem_address, e.a);
      chk("mem_wdata", mem_data_in, e.d);
      if (e.r && mem_we) begin
        if (after_fff) begin
          chk("ptr_wrap", mem_address, 0);
          wrap_seen++;
        end
        after_fff = (mem_address == {AW{1'b1}});
      end
    end
    ew = (rq0.size() > 0) && (rq0[0].cyc == c);
    chk("rsp0_valid", rsp0_valid, ew);
    if (ew) begin
      e = rq0.pop_front();
      chk("rsp0_rdata", rsp0_rdata, e.d);
    end
    ew = (rq1.size() > 0) && (rq1[0].cyc == c);
    chk("rsp1_valid", rsp1_valid, ew);
    if (ew) begin
      e = rq1.pop_front();
      chk("rsp1_rdata", rsp1_rdata, e.d);
    end
    if (rsp0_valid) last_rd0 = rsp0_rdata;
    if (rsp1_valid) last_rd1 = rsp1_rdata;
    chk("ref_count", ref_count, STATS ? m_cnt : 0);
    chk("ref_overrun", ref_overrun, STATS ? m_ovr : 1'b0);
    // short-interval instance: first wrap during its first burst lands at cycle 8
    chk("ovr_overrun", o_ovr, STATS && (c >= 8));
    chk("ovr_idle_port", {o_req0_ready, o_req1_ready, o_rsp0_valid, o_rsp1_valid, o_rsp0_rdata, o_rsp1_rdata}, 0);
    c++;
  endtask

  task automatic load_cmd(input int p, input cmd_t cm);
    v[p] = 1; cwe[p] = cm.we; ca[p] = cm.a; cd[p] = cm.d;
  endtask

  task automatic drive();
    cmd_t cm;
    for (int p = 0; p < 2; p++) begin
      if (acc[p]) v[p] = 0;
      if (!v[p]) begin
        if (mode == M_DIR && p == 0 && scr0.size() > 0) load_cmd(0, scr0.pop_front());
        else if (mode == M_DIR && p == 1 && scr1.size() > 0) load_cmd(1, scr1.pop_front());
        else if (mode == M_RND && $urandom_range(0, 3) != 0) begin
          cm.we = 1'($urandom_range(0, 1));
          cm.a  = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 31));
          cm.d  = DW'($urandom);
          load_cmd(p, cm);
        end
      end
    end
    req0_valid = v[0]; req0_we = cwe[0]; req0_addr = ca[0]; req0_wdata = cd[0];
    req1_valid = v[1]; req1_we = cwe[1]; req1_addr = ca[1]; req1_wdata = cd[1];
  endtask

  task automatic do_reset(input int n);
    rst_n = 0;
    v[0] = 0; v[1] = 0;
    req0_valid = 0; req1_valid = 0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_address, 0);
    chk("rst_mem_din", mem_data_in, 0);
    chk("rst_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
    chk("rst_rsp_rdata", {rsp0_rdata, rsp1_rdata}, 0);
    chk("rst_ready", {req0_ready, req1_ready}, 0);
    chk("rst_ref_count", ref_count, 0);
    chk("rst_ref_overrun", ref_overrun, 0);
    chk("rst_ovr_overrun", o_ovr, 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    model_reset();
    drive();
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      step_model();
      @(posedge clk);
      #1;
      drive();
    end
  endtask

  initial begin
    rst_n = 0;
    req0_valid = 0; req0_we = 0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 0; req1_we = 0; req1_addr = '0; req1_wdata = '0;
    mode = M_IDLE; wrap_seen = 0; last_rd0 = '0; last_rd1 = '0; ref_last_start = -1;
    for (int i = 0; i < (1 << AW); i++) mmem[i] = pat(i);
    repeat (4100) @(posedge clk);
    #1;

    // write 0xAA to 0x000 on port 0, then read it back
    mode = M_DIR;
    scr0.push_back('{1'b1, 12'h000, 8'hAA});
    scr0.push_back('{1'b0, 12'h000, 8'h00});
    do_reset(2);
    run_cycles(12);
    chk("dir_rdata", last_rd0, 8'hAA);

    // both ports reading continuously: grants alternate starting with port 0
    for (int i = 0; i < 4; i++) begin
      scr0.push_back('{1'b0, 12'h010, 8'h00});
      scr1.push_back('{1'b0, 12'h020, 8'h00});
    end
    grants.delete();
    do_reset(2);
    run_cycles(40);
    chk("grant_count", grants.size() >= 4, 1);
    for (int i = 0; i < 4 && i < grants.size(); i++) chk("grant_order", grants[i], i % 2);
    chk("rd_0x010", last_rd0, pat(12'h010));
    chk("rd_0x020", last_rd1, pat(12'h020));

    // long random traffic: sweep pointer passes 0xFFF -> 0x000
    mode = M_RND;
    run_cycles(33200);
    chk("wrap_seen", wrap_seen > 0, 1);
    chk("ovr_cnt_nz", o_cnt != 0, STATS);

    // reset while the controller sits in REF_CAP
    mode = M_IDLE;
    run_cycles(4);
    ref_last_start = -1;
    for (int i = 0; i < 100 && ref_last_start < 0; i++) begin
      @(negedge clk);
      step_model();
      @(posedge clk);
      #1;
      drive();
    end
    if (ref_last_start < 0) begin
      chk("ref_cap_found", 0, 1);
    end else begin
      run_cycles(1);
      do_reset(1);
      mode = M_RND;
      run_cycles(40);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
